// File: rtl/snoop_responder_if.sv
// Bus-side signal bundle for the snoop responder: snooped operations and table
// programming in, snoop results and status out.
interface snoop_responder_if #(
    parameter int addrWidth = 32,
    parameter int cntWidth  = 16
);
    logic                 opValid;
    logic [7:0]           opCode;
    logic [addrWidth-1:0] opAddr;
    logic                 progValid;
    logic [addrWidth-1:0] progAddr;
    logic [1:0]           progResult;
    logic                 snoopValid;
    logic [1:0]           snoopResult;
    logic                 busy;
    logic [cntWidth-1:0]  dropCount;

    modport slave (
        input  opValid, opCode, opAddr, progValid, progAddr, progResult,
        output snoopValid, snoopResult, busy, dropCount
    );

    modport master (
        output opValid, opCode, opAddr, progValid, progAddr, progResult,
        input  snoopValid, snoopResult, busy, dropCount
    );
endinterface

// File: rtl/snoop_responder.sv
// Models peer caches on the shared bus: answers each accepted snoop with
// HIT/HITM/NOHIT after a fixed latency, from a programmable line table or a nibble rule.
module snoop_responder #(
    parameter int addrWidth  = 32,
    parameter int numEntries = 8,
    parameter int latency    = 2,
    parameter int cntWidth   = 16
) (
    input  logic            clk,
    input  logic            reset,
    snoop_responder_if.slave io_bus
);
    localparam int IDX_W  = $clog2(numEntries);
    localparam int WCNT_W = (latency > 1) ? $clog2(latency) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic [WCNT_W-1:0]     w_wait_cnt_next;
    logic [1:0]            r_pending;
    logic                  r_snoop_valid;
    logic [1:0]            r_snoop_result;
    logic [cntWidth-1:0]   r_drop_count;

    logic [numEntries-1:0] r_valid;
    logic [addrWidth-1:0]  r_addr [numEntries];
    logic [1:0]            r_res  [numEntries];
    logic [IDX_W-1:0]      r_ptr;

    logic [numEntries-1:0] w_op_match;
    logic [numEntries-1:0] w_prog_match;
    logic                  w_op_hit;
    logic                  w_prog_hit;
    logic [IDX_W-1:0]      w_op_idx;
    logic [IDX_W-1:0]      w_prog_idx;
    logic [1:0]            w_op_table_res;
    logic [1:0]            w_lookup_res;
    logic                  w_snoopable;
    logic                  w_invalidating;
    logic                  w_accept;
    logic                  w_drop;

    function automatic logic [1:0] nibble_rule(input logic [3:0] nib);
        case (nib)
            4'h2, 4'h8: nibble_rule = 2'b01;
            4'h4, 4'hC: nibble_rule = 2'b10;
            default:    nibble_rule = 2'b00;
        endcase
    endfunction

    // Fully associative compare against every valid entry; addresses stay unique
    // because a new line is only allocated when no entry already matches.
    generate
        for (genvar gi = 0; gi < numEntries; gi++) begin : g_match
            assign w_op_match[gi]   = r_valid[gi] && (r_addr[gi] == io_bus.opAddr);
            assign w_prog_match[gi] = r_valid[gi] && (r_addr[gi] == io_bus.progAddr);
        end
    endgenerate

    always_comb begin
        w_op_idx       = '0;
        w_op_table_res = 2'b00;
        w_prog_idx     = '0;
        for (int i = 0; i < numEntries; i++) begin
            if (w_op_match[i]) begin
                w_op_idx       = IDX_W'(i);
                w_op_table_res = r_res[i];
            end
            if (w_prog_match[i]) begin
                w_prog_idx = IDX_W'(i);
            end
        end
    end

    assign w_op_hit       = |w_op_match;
    assign w_prog_hit     = |w_prog_match;
    assign w_lookup_res   = w_op_hit ? w_op_table_res : nibble_rule(io_bus.opAddr[3:0]);
    assign w_snoopable    = io_bus.opValid &&
                            (io_bus.opCode == 8'd1 || io_bus.opCode == 8'd2 ||
                             io_bus.opCode == 8'd3 || io_bus.opCode == 8'd4);
    assign w_invalidating = (io_bus.opCode == 8'd3) || (io_bus.opCode == 8'd4);
    assign w_accept       = w_snoopable && (r_state == S_IDLE);
    assign w_drop         = w_snoopable && (r_state != S_IDLE);

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next    = S_WAIT;
                    w_wait_cnt_next = WCNT_W'(latency - 1);
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = S_RESPOND;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - WCNT_W'(1);
                end
            end
            S_RESPOND: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_pending      <= 2'b00;
            r_snoop_valid  <= 1'b0;
            r_snoop_result <= 2'b00;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_snoop_valid <= (w_state_next == S_RESPOND);
            if (w_accept) begin
                r_pending <= w_lookup_res;
            end
            if (w_state_next == S_RESPOND) begin
                r_snoop_result <= r_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != {cntWidth{1'b1}})) begin
            r_drop_count <= r_drop_count + cntWidth'(1);
        end
    end

    // Program update comes after the snoop-invalidate clear so it wins on the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < numEntries; i++) begin
                r_addr[i] <= '0;
                r_res[i]  <= 2'b00;
            end
        end else begin
            if (w_accept && w_invalidating && w_op_hit) begin
                r_valid[w_op_idx] <= 1'b0;
            end
            if (io_bus.progValid) begin
                if (w_prog_hit) begin
                    if (io_bus.progResult == 2'b11) begin
                        r_valid[w_prog_idx] <= 1'b0;
                    end else begin
                        r_valid[w_prog_idx] <= 1'b1;
                        r_res[w_prog_idx]   <= io_bus.progResult;
                    end
                end else if (io_bus.progResult != 2'b11) begin
                    r_valid[r_ptr] <= 1'b1;
                    r_addr[r_ptr]  <= io_bus.progAddr;
                    r_res[r_ptr]   <= io_bus.progResult;
                    r_ptr          <= r_ptr + IDX_W'(1);
                end
            end
        end
    end

    assign io_bus.snoopValid  = r_snoop_valid;
    assign io_bus.snoopResult = r_snoop_result;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.dropCount   = r_drop_count;
endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder (default parameters, latency 2): hand-computed
// snoop results, latency, drop counting, table replacement and async reset.
module tb_snoop_responder;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    int   pulses;

    snoop_responder_if #(.addrWidth(32), .cntWidth(16)) bus ();

    snoop_responder #(
        .addrWidth (32),
        .numEntries(8),
        .latency   (2),
        .cntWidth  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic prog(input logic [31:0] addr, input logic [1:0] res);
        bus.progValid  = 1'b1;
        bus.progAddr   = addr;
        bus.progResult = res;
        @(posedge clk); #1;
        bus.progValid  = 1'b0;
        $display("prog addr=0x%08h result=%02b", addr, res);
    endtask

    // One snoop from idle: busy right after acceptance, pulse exactly 2 edges later,
    // result held afterwards. Optionally programs the table in the acceptance cycle.
    task automatic req(input logic [7:0] code, input logic [31:0] addr, input logic [1:0] exp,
                       input string tag, input logic pv = 1'b0,
                       input logic [31:0] pa = 32'h0, input logic [1:0] pr = 2'b00);
        bus.opValid    = 1'b1;
        bus.opCode     = code;
        bus.opAddr     = addr;
        bus.progValid  = pv;
        bus.progAddr   = pa;
        bus.progResult = pr;
        @(posedge clk); #1;
        bus.opValid   = 1'b0;
        bus.progValid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_v0"}, 32'(bus.snoopValid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_v1"}, 32'(bus.snoopValid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.snoopValid), 32'd1);
        chk({tag, "_res"}, 32'(bus.snoopResult), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_v3"}, 32'(bus.snoopValid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, 32'(bus.snoopResult), 32'(exp));
        $display("req %s op=%0d addr=0x%08h result=%02b expected=%02b",
                 tag, code, addr, bus.snoopResult, exp);
    endtask

    initial begin
        n_total        = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.opValid    = 1'b0;
        bus.opCode     = 8'd0;
        bus.opAddr     = 32'h0;
        bus.progValid  = 1'b0;
        bus.progAddr   = 32'h0;
        bus.progResult = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.snoopValid), 32'd0);
        chk("rst_result", 32'(bus.snoopResult), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_drop", 32'(bus.dropCount), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Nibble rule on an empty table
        req(8'd1, 32'h0000_1002, 2'b01, "nib_hit");
        req(8'd1, 32'h0000_100C, 2'b10, "nib_hitm");
        req(8'd1, 32'h0000_1005, 2'b00, "nib_nohit");

        // Table overrides nibble rule, then removal falls back
        prog(32'h0000_2002, 2'b10);
        req(8'd1, 32'h0000_2002, 2'b10, "tbl_override");
        prog(32'h0000_2002, 2'b11);
        req(8'd1, 32'h0000_2002, 2'b01, "tbl_removed");

        // RWIM reports pre-clear result and clears the entry
        prog(32'h0000_3000, 2'b01);
        req(8'd4, 32'h0000_3000, 2'b01, "rwim_hit");
        req(8'd1, 32'h0000_3000, 2'b00, "rwim_cleared");

        // Six back-to-back snoopable requests: two accepted, four dropped
        bus.opValid = 1'b1;
        bus.opCode  = 8'd1;
        bus.opAddr  = 32'h0000_1002;
        pulses      = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i == 5) bus.opValid = 1'b0;
            if (bus.snoopValid) pulses++;
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_drop", 32'(bus.dropCount), 32'd4);
        chk("b2b_idle", 32'(bus.busy), 32'd0);
        $display("b2b pulses=%0d dropCount=%0d", pulses, bus.dropCount);

        // Non-snoopable opcode while busy is not counted
        bus.opValid = 1'b1;
        bus.opCode  = 8'd1;
        bus.opAddr  = 32'h0000_1005;
        @(posedge clk); #1;
        bus.opCode  = 8'h07;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.opValid = 1'b0;
        chk("op7_pulse", 32'(bus.snoopValid), 32'd1);
        chk("op7_res", 32'(bus.snoopResult), 32'd0);
        chk("op7_drop", 32'(bus.dropCount), 32'd4);
        @(posedge clk); #1;
        chk("op7_idle", 32'(bus.busy), 32'd0);
        $display("op7 while busy dropCount=%0d", bus.dropCount);

        // Nine distinct lines into eight entries: the first is evicted
        for (int k = 0; k < 9; k++) prog(32'h0000_4000 + 32'(k * 16), 2'b01);
        req(8'd1, 32'h0000_4000, 2'b00, "evict_first");
        req(8'd1, 32'h0000_4080, 2'b01, "ninth_hit");
        req(8'd1, 32'h0000_4010, 2'b01, "second_kept");

        // Same-cycle invalidate and program of one entry: program wins
        req(8'd3, 32'h0000_4010, 2'b01, "inv_prog_same", 1'b1, 32'h0000_4010, 2'b10);
        req(8'd1, 32'h0000_4010, 2'b10, "prog_wins");

        // Lookup sees the table before the same-cycle program write
        req(8'd1, 32'h0000_6002, 2'b01, "pre_write", 1'b1, 32'h0000_6002, 2'b10);
        req(8'd1, 32'h0000_6002, 2'b10, "post_write");

        // Asynchronous reset while waiting discards the response
        bus.opValid = 1'b1;
        bus.opCode  = 8'd1;
        bus.opAddr  = 32'h0000_1002;
        @(posedge clk); #1;
        bus.opValid = 1'b0;
        chk("arst_busy_before", 32'(bus.busy), 32'd1);
        chk("arst_drop_before", 32'(bus.dropCount), 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_drop", 32'(bus.dropCount), 32'd0);
        chk("arst_valid", 32'(bus.snoopValid), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.snoopValid) pulses++;
        end
        chk("arst_no_pulse", 32'(pulses), 32'd0);
        $display("async reset in WAIT: pulses afterwards=%0d", pulses);
        req(8'd1, 32'h0000_0004, 2'b10, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
